// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared types and constants for the conv neuron sequencer
package conv_seq_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} seq_state_t;

    localparam int DEF_WEIGHT_MEM_ORDER = 5;
    localparam int FIFO_ORDER           = DEF_WEIGHT_MEM_ORDER + 1;
    localparam int NEURON_OUT_LATENCY   = 8;

    // One extra address bit lets a FIFO hold a full kernel plus bias with room to spare
    function automatic int fifo_order(input int weight_mem_order);
        return weight_mem_order + 1;
    endfunction

endpackage

// File: rtl/conv_seq_fifo.sv
// conv_seq_fifo: first-word-fall-through synchronous FIFO with occupancy count
module conv_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int ORDER = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [ORDER:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 2 ** ORDER;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ORDER-1:0] wr_q, rd_q;
    logic [ORDER:0]   cnt_q;
    logic             wr_en, rd_en;

    assign full_o  = cnt_q == (ORDER+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + ORDER'(wr_en);
            rd_q  <= rd_q + ORDER'(rd_en);
            cnt_q <= cnt_q + (ORDER+1)'(wr_en) - (ORDER+1)'(rd_en);
        end
    end

endmodule

// File: rtl/conv_neuron_seq.sv
// conv_neuron_seq: loads bias/weights into a lockstep neuron bank, streams
// feature windows and counts returned outputs to signal completion
module conv_neuron_seq
    import conv_seq_pkg::*;
#(
    parameter int FEATURE_WIDTH    = 8,
    parameter int WEIGHT_WIDTH     = 8,
    parameter int WEIGHT_MEM_ORDER = DEF_WEIGHT_MEM_ORDER,
    parameter int KERNEL_LEN       = 25,
    parameter int NUM_NEURONS      = 4,
    parameter int NUM_WINDOWS      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic [WEIGHT_WIDTH-1:0]  w_data,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [FEATURE_WIDTH-1:0] f_data,
    input  logic                     f_valid,
    output logic                     f_ready,
    output logic [WEIGHT_WIDTH-1:0]  n_weight_stream,
    output logic [NUM_NEURONS-1:0]   n_weight_first,
    output logic [NUM_NEURONS-1:0]   n_weight_last,
    output logic [FEATURE_WIDTH-1:0] n_feature_stream,
    output logic                     n_feature_first,
    output logic                     n_feature_last,
    input  logic                     n_output_valid,
    output logic [15:0]              win_issued
);

    localparam int FORD = fifo_order(WEIGHT_MEM_ORDER);
    localparam int NIW  = $clog2(NUM_NEURONS) + 1;
    localparam int TW   = WEIGHT_MEM_ORDER + 1;

    seq_state_t state_q, state_d;
    logic [NIW-1:0] ni_q, ni_d;
    logic [TW-1:0] wtap_q, wtap_d, ftap_q, ftap_d;
    logic gap_q, gap_d;
    logic [15:0] win_q, win_d, ocnt_q, ocnt_d;
    logic [WEIGHT_WIDTH-1:0] nws_q, nws_d;
    logic [NUM_NEURONS-1:0] nwf_q, nwf_d, nwl_q, nwl_d;
    logic [FEATURE_WIDTH-1:0] nfs_q, nfs_d;
    logic nff_q, nff_d, nfl_q, nfl_d;

    logic [FORD:0] wcnt, fcnt;
    logic wfull, ffull, wempty, fempty;
    logic [WEIGHT_WIDTH-1:0] w_head;
    logic [FEATURE_WIDTH-1:0] f_head;
    logic start_run, wpop, wfirst, wlast, fpop, ffirst, flast;
    logic [16:0] ocnt_nx;
    logic [NUM_NEURONS-1:0] ni_hot;

    conv_seq_fifo #(.WIDTH(WEIGHT_WIDTH), .ORDER(FORD)) u_wfifo (
        .clk(clk), .rst_n(rst_n), .push_i(w_valid), .pop_i(wpop), .data_i(w_data),
        .data_o(w_head), .count_o(wcnt), .full_o(wfull), .empty_o(wempty)
    );

    conv_seq_fifo #(.WIDTH(FEATURE_WIDTH), .ORDER(FORD)) u_ffifo (
        .clk(clk), .rst_n(rst_n), .push_i(f_valid), .pop_i(fpop), .data_i(f_data),
        .data_o(f_head), .count_o(fcnt), .full_o(ffull), .empty_o(fempty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = LOAD_W;
            LOAD_W: if (wlast && ni_q == NIW'(NUM_NEURONS - 1)) state_d = STREAM;
            STREAM: if (flast && win_q == 16'(NUM_WINDOWS - 1)) state_d = DRAIN;
            DRAIN:  if (done) state_d = IDLE;
        endcase
    end

    // A burst or window only starts once it is fully buffered, so it never stalls midway
    always_comb begin
        start_run = state_q == IDLE && start;
        wpop      = state_q == LOAD_W && !wempty &&
                    (wtap_q != '0 || (!gap_q && wcnt >= (FORD+1)'(KERNEL_LEN + 1)));
        wfirst    = wpop && wtap_q == '0;
        wlast     = wpop && wtap_q == TW'(KERNEL_LEN);
        fpop      = state_q == STREAM && !fempty &&
                    (ftap_q != '0 || fcnt >= (FORD+1)'(KERNEL_LEN));
        ffirst    = fpop && ftap_q == '0;
        flast     = fpop && ftap_q == TW'(KERNEL_LEN - 1);
        ocnt_nx   = {1'b0, ocnt_q} + 17'(n_output_valid);
        done      = state_q == DRAIN && ocnt_nx >= 17'(NUM_WINDOWS);
        ni_hot    = NUM_NEURONS'(1) << ni_q;
    end

    always_comb begin
        ni_d   = start_run ? '0 : ni_q + NIW'(wlast);
        wtap_d = wlast ? '0 : wtap_q + TW'(wpop);
        ftap_d = flast ? '0 : ftap_q + TW'(fpop);
        gap_d  = wlast;
        win_d  = start_run ? '0 : win_q + 16'(flast);
        ocnt_d = start_run ? '0 : (state_q == STREAM || state_q == DRAIN) ? ocnt_nx[15:0] : ocnt_q;
        nws_d  = wpop ? w_head : nws_q;
        nwf_d  = wfirst ? ni_hot : '0;
        nwl_d  = wlast ? ni_hot : '0;
        nfs_d  = fpop ? f_head : nfs_q;
        nff_d  = ffirst;
        nfl_d  = flast;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ni_q   <= '0;
            wtap_q <= '0;
            ftap_q <= '0;
            gap_q  <= 1'b0;
            win_q  <= '0;
            ocnt_q <= '0;
            nws_q  <= '0;
            nwf_q  <= '0;
            nwl_q  <= '0;
            nfs_q  <= '0;
            nff_q  <= 1'b0;
            nfl_q  <= 1'b0;
        end else begin
            ni_q   <= ni_d;
            wtap_q <= wtap_d;
            ftap_q <= ftap_d;
            gap_q  <= gap_d;
            win_q  <= win_d;
            ocnt_q <= ocnt_d;
            nws_q  <= nws_d;
            nwf_q  <= nwf_d;
            nwl_q  <= nwl_d;
            nfs_q  <= nfs_d;
            nff_q  <= nff_d;
            nfl_q  <= nfl_d;
        end
    end

    assign busy             = state_q != IDLE;
    assign w_ready          = !wfull;
    assign f_ready          = !ffull;
    assign n_weight_stream  = nws_q;
    assign n_weight_first   = nwf_q;
    assign n_weight_last    = nwl_q;
    assign n_feature_stream = nfs_q;
    assign n_feature_first  = nff_q;
    assign n_feature_last   = nfl_q;
    assign win_issued       = win_q;

endmodule

// File: tb/tb_conv_neuron_seq.sv
// tb_conv_neuron_seq: directed scoreboard bench for the conv neuron sequencer
module tb_conv_neuron_seq;
  import conv_seq_pkg::*;
  localparam int K  = 4;
  localparam int N  = 2;
  localparam int NW = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic w_valid = 1'b0, f_valid = 1'b0, n_output_valid = 1'b0;
  logic [7:0] w_data = '0, f_data = '0;
  logic busy, done, w_ready, f_ready, n_feature_first, n_feature_last;
  logic [7:0] n_weight_stream, n_feature_stream;
  logic [N-1:0] n_weight_first, n_weight_last;
  logic [15:0] win_issued;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  typedef struct packed {logic [7:0] d; logic [N-1:0] f; logic [N-1:0] l;} wexp_t;
  typedef struct packed {logic [7:0] d; logic f; logic l;} fexp_t;
  wexp_t wq[$];
  fexp_t fq[$];
  int wi = 0, fi = 0;
  always #5 clk = ~clk;
  conv_neuron_seq #(
    .FEATURE_WIDTH(8), .WEIGHT_WIDTH(8), .WEIGHT_MEM_ORDER(5),
    .KERNEL_LEN(K), .NUM_NEURONS(N), .NUM_WINDOWS(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .n_weight_stream(n_weight_stream), .n_weight_first(n_weight_first),
    .n_weight_last(n_weight_last), .n_feature_stream(n_feature_stream),
    .n_feature_first(n_feature_first), .n_feature_last(n_feature_last),
    .n_output_valid(n_output_valid), .win_issued(win_issued)
  );
  logic [NEURON_OUT_LATENCY:0] sr = '0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) sr = '0;
    else sr = {sr[NEURON_OUT_LATENCY-1:0], n_feature_last};
    n_output_valid = sr[NEURON_OUT_LATENCY];
  end
  int fpush = 0;
  always @(posedge clk) begin
    if (!rst_n) fpush = 0;
    else if (f_valid && f_ready) fpush++;
  end
  int wrem = 0, frem = 0, wbursts = 0, fseen = 0, fpush_prev = 0, vcnt = 0, dcnt = 0, cyc = 0;
  bit wprev_last = 1'b0;
  int firsts[$];
  always @(negedge clk) begin
    wexp_t we, wo;
    fexp_t fe, fo;
    cyc++;
    if (!rst_n) begin
      wrem = 0; frem = 0; fseen = 0; vcnt = 0; wprev_last = 1'b0;
    end else begin
      if (n_weight_first != '0 || wrem > 0) begin
        if (n_weight_first != '0) begin
          wbursts++;
          chk("w_gap", wprev_last, 1'b0);
          wrem = K + 1;
        end
        wo = '{n_weight_stream, n_weight_first, n_weight_last};
        we = wq.size() > 0 ? wq.pop_front() : 'x;
        chk("w_word", wo, we);
        wrem--;
      end else if (n_weight_last != '0) chk("w_stray_last", n_weight_last, '0);
      wprev_last = n_weight_last != '0;
      if (n_feature_first || frem > 0) begin
        if (n_feature_first) begin
          firsts.push_back(cyc);
          chk("f_buffered", (fpush_prev - fseen) >= K, 1'b1);
          frem = K;
        end
        fo = '{n_feature_stream, n_feature_first, n_feature_last};
        fe = fq.size() > 0 ? fq.pop_front() : 'x;
        chk("f_word", fo, fe);
        frem--;
        fseen++;
      end else if (n_feature_last) chk("f_stray_last", n_feature_last, 1'b0);
      chk("done", done, n_output_valid && (vcnt + 1 == NW));
      if (n_output_valid) vcnt++;
      if (done) begin dcnt++; vcnt = 0; end
    end
    fpush_prev = fpush;
  end
  task automatic push_w(input logic [7:0] d);
    wexp_t e;
    e.d = d;
    e.f = (wi % (K + 1) == 0) ? N'(1) << (wi / (K + 1)) : '0;
    e.l = (wi % (K + 1) == K) ? N'(1) << (wi / (K + 1)) : '0;
    wq.push_back(e);
    wi++;
    w_data = d; w_valid = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
  endtask
  task automatic push_f(input logic [7:0] d);
    fexp_t e;
    e.d = d; e.f = (fi % K == 0); e.l = (fi % K == K - 1);
    fq.push_back(e);
    fi++;
    f_data = d; f_valid = 1'b1;
    @(negedge clk);
    f_valid = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    bit got = 1'b0;
    for (int c = 0; c < lim && !got; c++) begin
      @(negedge clk);
      got = done;
    end
    checks++;
    if (!got) begin
      errors++;
      $error("FAIL done_seen: no done within %0d cycles", lim);
    end
    @(negedge clk);
    chk("busy_after_done", busy, 1'b0);
  endtask
  initial begin
    logic [7:0] wa [10];
    int wb0, d0, f0;
    bit got;
    wa = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 8'h05, 8'h06, 8'h07, 8'h08};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_w_ready", w_ready, 1'b1);
    chk("rst_f_ready", f_ready, 1'b1);
    chk("rst_nw_first", n_weight_first, 2'b00);
    chk("rst_nw_last", n_weight_last, 2'b00);
    chk("rst_nw_stream", n_weight_stream, 8'h00);
    chk("rst_nf_stream", n_feature_stream, 8'h00);
    chk("rst_nf_first", n_feature_first, 1'b0);
    chk("rst_nf_last", n_feature_last, 1'b0);
    chk("rst_win", win_issued, 16'd0);
    wb0 = wbursts; d0 = dcnt; f0 = firsts.size();
    for (int i = 0; i < 12; i++) push_f(8'h10 + 8'(i));
    pulse_start();
    wi = 0;
    for (int i = 0; i < 10; i++) begin
      push_w(wa[i]);
      if (i == 5) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(200);
    chk("a_win_issued", win_issued, 16'd3);
    chk("a_done_once", dcnt - d0, 1);
    chk("a_bursts", wbursts - wb0, 2);
    chk("a_b2b_gap1", firsts[f0 + 1] - firsts[f0], 4);
    chk("a_b2b_gap2", firsts[f0 + 2] - firsts[f0 + 1], 4);
    chk("a_wq_empty", wq.size(), 0);
    chk("a_fq_empty", fq.size(), 0);
    d0 = dcnt; wb0 = wbursts;
    pulse_start();
    wi = 0;
    for (int i = 0; i < 10; i++) push_w(wa[i] + 8'h20);
    for (int i = 0; i < 12; i++) begin
      push_f(8'h40 + 8'(i));
      repeat (2) @(negedge clk);
    end
    wait_done(200);
    chk("b_win_issued", win_issued, 16'd3);
    chk("b_done_once", dcnt - d0, 1);
    chk("b_bursts", wbursts - wb0, 2);
    chk("b_fq_empty", fq.size(), 0);
    d0 = dcnt;
    for (int i = 0; i < 12; i++) push_f(8'h60 + 8'(i));
    pulse_start();
    wi = 0;
    for (int i = 0; i < 10; i++) push_w(wa[i] + 8'h30);
    w_data = 8'hEE; w_valid = 1'b1;
    repeat (3) @(negedge clk);
    w_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = win_issued == 16'd1;
    end
    chk("c_win1_seen", got, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("c_rst_busy", busy, 1'b0);
    chk("c_rst_done", done, 1'b0);
    chk("c_rst_wcount", dut.u_wfifo.count_o, 7'd0);
    chk("c_rst_fcount", dut.u_ffifo.count_o, 7'd0);
    chk("c_rst_win", win_issued, 16'd0);
    chk("c_rst_nf_first", n_feature_first, 1'b0);
    wq.delete(); fq.delete(); wi = 0; fi = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("c_no_done", dcnt - d0, 0);
    chk("c_idle", busy, 1'b0);
    for (int i = 0; i < 12; i++) push_f(8'h80 + 8'(i));
    pulse_start();
    wi = 0;
    for (int i = 0; i < 10; i++) push_w(wa[i] + 8'h50);
    wait_done(200);
    chk("d_win_issued", win_issued, 16'd3);
    chk("d_done_once", dcnt - d0, 1);
    chk("d_wq_empty", wq.size(), 0);
    chk("d_fq_empty", fq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
